// File: rtl/timetag_pkg.sv
// Constants shared by the timestamp record path (record_stream_packer and apdtimer).
// Record widths are derived from a byte count so both blocks agree on the layout.
package timetag_pkg;

    localparam int BYTE_W            = 8;
    localparam int REC_BYTES_DEFAULT = 6;

    function automatic int rec_w(input int rec_bytes);
        return BYTE_W * rec_bytes;
    endfunction

    // The top bit of a stored record carries the "a record was lost before this one" flag.
    function automatic int lost_bit(input int rec_bytes);
        return BYTE_W * rec_bytes - 1;
    endfunction

endpackage

// File: rtl/record_fifo_sc.sv
// Single-clock first-word-fall-through FIFO.
// rd_data always shows the head entry; a push and a pop may happen in the same cycle.
module record_fifo_sc #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // When full, a push is only legal alongside a pop; the pop reads the slot before it is rewritten.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/record_stream_packer.sv
// Buffers timestamp records, tags records that follow a drop, and serialises them LSB byte first.
// Build option RECORD_STREAM_DROP_COUNT_EN enables the saturating drop counter; otherwise drop_count is 0.
module record_stream_packer
    import timetag_pkg::*;
#(
    parameter  int REC_BYTES = REC_BYTES_DEFAULT,
    parameter  int DEPTH     = 16,
    parameter  int CNT_W     = 16,
    localparam int REC_W     = rec_w(REC_BYTES),
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               record_rdy,
    input  logic [REC_W-2:0]   record,
    input  logic               flush,
    output logic               data_rdy,
    output logic [BYTE_W-1:0]  data,
    input  logic               data_ack,
    output logic [LVL_W-1:0]   buf_level,
    output logic               rec_lost,
    output logic [CNT_W-1:0]   drop_count
);

    localparam int LOST_BIT = lost_bit(REC_BYTES);
    localparam int BIDX_W   = $clog2(REC_BYTES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [REC_W-1:0]  shift_q, shift_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic              rec_lost_q, rec_lost_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  fifo_rd_data;
    logic [REC_W-1:0]  fifo_wr_data;
    logic              accept;
    logic              drop;

    assign accept = record_rdy && !flush && (!fifo_full || fifo_pop);
    assign drop   = record_rdy && !flush && fifo_full && !fifo_pop;

    assign fifo_wr_data[LOST_BIT]   = rec_lost_q;
    assign fifo_wr_data[REC_W-2:0]  = record;

    record_fifo_sc #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (accept),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .level   (buf_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The final-byte ack reloads straight from the FIFO head so consecutive records have no gap.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        fifo_pop   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_rd_data;
                        byte_idx_d = '0;
                        state_d    = ST_SEND;
                    end
                end
                default: begin
                    if (data_ack) begin
                        if (byte_idx_q == BIDX_W'(REC_BYTES - 1)) begin
                            if (!fifo_empty) begin
                                fifo_pop   = 1'b1;
                                shift_d    = fifo_rd_data;
                                byte_idx_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            shift_d    = {{BYTE_W{1'b0}}, shift_q[REC_W-1:BYTE_W]};
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rec_lost_d = rec_lost_q;
        if (accept) begin
            rec_lost_d = 1'b0;
        end else if (drop) begin
            rec_lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            rec_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            rec_lost_q <= rec_lost_d;
        end
    end

    assign data_rdy = (state_q == ST_SEND);
    assign data     = shift_q[BYTE_W-1:0];
    assign rec_lost = rec_lost_q;

`ifdef RECORD_STREAM_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != {CNT_W{1'b1}})) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule
